// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the shared ALU connection, the response
// port and the grant counters around alu_arbiter.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_instr;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_instr;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [31:0] alu_instr;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic [2:0]  alu_flags;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_flags;
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;

  modport slave (
    input  req0_valid, req0_instr, req0_a, req0_b,
    input  req1_valid, req1_instr, req1_a, req1_b,
    input  alu_result, alu_flags, rsp_ready,
    output req0_ready, req1_ready, alu_instr, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_result, rsp_flags, grant_cnt0, grant_cnt1
  );

  modport master (
    output req0_valid, req0_instr, req0_a, req0_b,
    output req1_valid, req1_instr, req1_a, req1_b,
    output alu_result, alu_flags, rsp_ready,
    input  req0_ready, req1_ready, alu_instr, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags, grant_cnt0, grant_cnt1
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared combinational ALU,
// with a single registered response slot and saturating per-requester counters.
module alu_arbiter #(
  parameter bit FIRST_PRIO = 1'b0
) (
  input logic        clock,
  input logic        reset,
  alu_arbiter_if.slave bus
);
  logic [1:0]  req_valid;
  logic        accept;
  logic        grant_any;
  logic        grant_id;
  logic [1:0]  grant_onehot;
  logic        rsp_valid_reg;
  logic        rsp_id_reg;
  logic [31:0] rsp_result_reg;
  logic [2:0]  rsp_flags_reg;
  logic        last_grant_reg;
  logic [15:0] grant_cnt_reg [2];

  assign req_valid = {bus.req1_valid, bus.req0_valid};

  // A grant is only issued when the response slot can take the result this cycle.
  always_comb begin
    accept    = !rsp_valid_reg || bus.rsp_ready;
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (!reset && accept) begin
      case (req_valid)
        2'b01: begin grant_any = 1'b1; grant_id = 1'b0; end
        2'b10: begin grant_any = 1'b1; grant_id = 1'b1; end
        2'b11: begin grant_any = 1'b1; grant_id = ~last_grant_reg; end
        default: ;
      endcase
    end
  end

  assign grant_onehot   = {grant_any && grant_id, grant_any && !grant_id};
  assign bus.req0_ready = grant_onehot[0];
  assign bus.req1_ready = grant_onehot[1];

  assign bus.alu_instr = !grant_any ? 32'd0 : (grant_id ? bus.req1_instr : bus.req0_instr);
  assign bus.alu_a     = !grant_any ? 32'd0 : (grant_id ? bus.req1_a     : bus.req0_a);
  assign bus.alu_b     = !grant_any ? 32'd0 : (grant_id ? bus.req1_b     : bus.req0_b);

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= 1'b0;
      rsp_result_reg <= 32'd0;
      rsp_flags_reg  <= 3'd0;
      last_grant_reg <= ~FIRST_PRIO;
    end else if (grant_any) begin
      rsp_valid_reg  <= 1'b1;
      rsp_id_reg     <= grant_id;
      rsp_result_reg <= bus.alu_result;
      rsp_flags_reg  <= bus.alu_flags;
      last_grant_reg <= grant_id;
    end else if (rsp_valid_reg && bus.rsp_ready) begin
      rsp_valid_reg  <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clock) begin
        if (reset) begin
          grant_cnt_reg[gi] <= 16'd0;
        end else if (grant_onehot[gi] && grant_cnt_reg[gi] != 16'hFFFF) begin
          grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 16'd1;
        end
      end
    end
  endgenerate

  assign bus.rsp_valid  = rsp_valid_reg;
  assign bus.rsp_id     = rsp_id_reg;
  assign bus.rsp_result = rsp_result_reg;
  assign bus.rsp_flags  = rsp_flags_reg;
  assign bus.grant_cnt0 = grant_cnt_reg[0];
  assign bus.grant_cnt1 = grant_cnt_reg[1];
endmodule
